// File: rtl/avst_test_pkg.sv
// Shared types and constants for the Avalon-ST test source.
package avst_test_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} src_state_t;

  localparam logic [15:0] HDR_MAGIC = 16'hA55A;
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  function automatic int empty_w(input int width);
    return $clog2(width / 8);
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/avst_test_source_sync_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector (one-cycle pulse).
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  // sr[0], sr[1]: synchroniser stages; sr[2]: previous synchronised level
  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (rst) sr <= '0;
    else     sr <= {sr[1:0], din};
  end

  assign rise = sr[1] & ~sr[2];

endmodule

// File: rtl/avst_test_source.sv
// Avalon-ST test source: emits one fixed-length packet per start event (or back to back
// when continuous). Optional macro AVST_SRC_LFSR_EN selects an LFSR payload.
module avst_test_source
  import avst_test_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PKT_WORDS  = 16,
  parameter int unsigned LAST_EMPTY = 0,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       continuous,
  input  logic                       ready,
  output logic                       valid,
  output logic [WIDTH-1:0]           data,
  output logic                       sop,
  output logic                       eop,
  output logic [empty_w(WIDTH)-1:0]  empty,
  output logic                       busy,
  output logic [15:0]                pkt_count
);

  localparam int unsigned EW = empty_w(WIDTH);
  localparam int unsigned IW = $clog2(PKT_WORDS);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(PKT_WORDS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);
  localparam logic [EW-1:0] EMPTY_EOP = EW'(LAST_EMPTY);

  src_state_t      state, state_nxt;
  logic [IW-1:0]   idx, idx_nxt, idx_inc;
  logic [GW-1:0]   gap_cnt, gap_nxt;
  logic [15:0]     seq, seq_nxt, cnt_nxt;
  logic            valid_nxt, sop_nxt, eop_nxt;
  logic [WIDTH-1:0] data_nxt, payload;
  logic [EW-1:0]   empty_nxt;
  logic            start_evt;

  sync_edge_det u_start_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (start),
    .rise (start_evt)
  );

  assign idx_inc = idx + IW'(1);

`ifdef AVST_SRC_LFSR_EN
  logic [31:0] lfsr, lfsr_nxt, lfsr_adv;

  assign lfsr_adv = lfsr_step(lfsr);

  always_comb begin
    payload = '0;
    for (int unsigned b = 0; b < WIDTH; b++) payload[b] = lfsr_adv[b % 32];
  end
`else
  assign payload = WIDTH'({seq, 16'(idx_inc)});
`endif

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    gap_nxt   = gap_cnt;
    seq_nxt   = seq;
    cnt_nxt   = pkt_count;
    valid_nxt = valid;
    data_nxt  = data;
    sop_nxt   = sop;
    eop_nxt   = eop;
    empty_nxt = empty;
`ifdef AVST_SRC_LFSR_EN
    lfsr_nxt  = lfsr;
`endif
    unique case (state)
      IDLE: begin
        if (start_evt || continuous) begin
          state_nxt = SEND;
          idx_nxt   = '0;
          valid_nxt = 1'b1;
          data_nxt  = WIDTH'({HDR_MAGIC, seq});
          sop_nxt   = 1'b1;
          eop_nxt   = 1'b0;
          empty_nxt = '0;
`ifdef AVST_SRC_LFSR_EN
          lfsr_nxt  = LFSR_SEED;
`endif
        end
      end
      SEND: begin
        // Outputs only move on a transfer, so a stalled beat stays put.
        if (valid && ready) begin
          if (eop) begin
            state_nxt = GAP;
            gap_nxt   = '0;
            valid_nxt = 1'b0;
            data_nxt  = '0;
            sop_nxt   = 1'b0;
            eop_nxt   = 1'b0;
            empty_nxt = '0;
            seq_nxt   = seq + 16'd1;
            cnt_nxt   = pkt_count + 16'd1;
          end else begin
            idx_nxt   = idx_inc;
            data_nxt  = payload;
            sop_nxt   = 1'b0;
            eop_nxt   = (idx_inc == LAST_IDX);
            empty_nxt = (idx_inc == LAST_IDX) ? EMPTY_EOP : '0;
`ifdef AVST_SRC_LFSR_EN
            lfsr_nxt  = lfsr_adv;
`endif
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_nxt   = gap_cnt + GW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      seq       <= '0;
      pkt_count <= '0;
      valid     <= 1'b0;
      data      <= '0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      empty     <= '0;
`ifdef AVST_SRC_LFSR_EN
      lfsr      <= '0;
`endif
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      gap_cnt   <= gap_nxt;
      seq       <= seq_nxt;
      pkt_count <= cnt_nxt;
      valid     <= valid_nxt;
      data      <= data_nxt;
      sop       <= sop_nxt;
      eop       <= eop_nxt;
      empty     <= empty_nxt;
`ifdef AVST_SRC_LFSR_EN
      lfsr      <= lfsr_nxt;
`endif
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_avst_test_source.sv
// Scoreboard bench for avst_test_source: expected packets are queued when stimulus is
// issued and a negedge monitor pops/compares every accepted beat.
module tb_avst_test_source;

  localparam int unsigned W    = 32;
  localparam int unsigned PKT  = 16;
  localparam int unsigned LE   = 0;
  localparam int unsigned GAPC = 4;
  localparam int unsigned EW   = $clog2(W / 8);
`ifdef AVST_SRC_LFSR_EN
  localparam logic [W-1:0] BEAT1_EXP = 32'hD650_8003;
`else
  localparam logic [W-1:0] BEAT1_EXP = 32'h0000_0001;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic          ready = 1'b0;
  logic          valid, sop, eop, busy;
  logic [W-1:0]  data;
  logic [EW-1:0] empty;
  logic [15:0]   pkt_count;

  avst_test_source #(
    .WIDTH      (W),
    .PKT_WORDS  (PKT),
    .LAST_EMPTY (LE),
    .GAP_CYCLES (GAPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .continuous (continuous),
    .ready      (ready),
    .valid      (valid),
    .data       (data),
    .sop        (sop),
    .eop        (eop),
    .empty      (empty),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]  data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } beat_t;

  beat_t       exp_q[$];
  logic [W-1:0] hdrs[$];
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned model_seq = 0;
  int unsigned model_cnt = 0;
  int          ready_mode = 0;
  int          cyc = 0;

  // monitor state
  bit          prev_stall = 0, in_pkt = 0, after_eop = 0;
  logic [W+EW+1:0] prev_beat = '0;
  int          bidx = 0, sop_cnt = 0, eop_cnt = 0, gap_run = 0, sop_cyc = 0, eop_cyc = 0;
  logic [W-1:0] last_beat1 = '0, last_hdr = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Payload as defined by the packet format, from the seed/sequence alone.
  function automatic logic [W-1:0] ref_payload(input int unsigned seqn, input int unsigned k);
    logic [W-1:0] d;
`ifdef AVST_SRC_LFSR_EN
    logic [31:0] r;
    r = 32'hACE1_0001;
    for (int unsigned i = 0; i < k; i++) r = r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
    for (int unsigned b = 0; b < W; b++) d[b] = r[b % 32];
`else
    d = W'(((seqn & 32'hFFFF) << 16) | (k & 32'hFFFF));
`endif
    return d;
  endfunction

  task automatic push_packet();
    beat_t b;
    for (int unsigned k = 0; k < PKT; k++) begin
      b.data  = (k == 0) ? W'(32'hA55A_0000 | (model_seq & 32'hFFFF)) : ref_payload(model_seq, k);
      b.sop   = (k == 0);
      b.eop   = (k == PKT - 1);
      b.empty = (k == PKT - 1) ? EW'(LE) : '0;
      exp_q.push_back(b);
    end
    model_seq = (model_seq + 1) % 65536;
    model_cnt = (model_cnt + 1) % 65536;
  endtask

  function automatic int mon_val(input int sel);
    case (sel)
      0:       return eop_cnt;
      1:       return sop_cnt;
      default: return in_pkt ? bidx + 1 : 0;
    endcase
  endfunction

  task automatic wait_mon(input string name, input int sel, input int target, input int budget);
    int n = 0;
    while (mon_val(sel) < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(name, 64'(mon_val(sel) >= target), 64'(1));
  endtask

  task automatic pulse_start(input int pre);
    repeat (pre) @(posedge clk);
    @(posedge clk); #1 start = 1'b1;
    repeat (3) @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    exp_q.delete();
    model_seq = 0;
    model_cnt = 0;
    #1 rst = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    case (ready_mode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      2:       ready = ($urandom % 4) != 0;
      default: ready = 1'b0;
    endcase
  end

  initial forever begin
    beat_t e;
    @(negedge clk);
    if (rst) begin
      prev_stall = 0;
      in_pkt     = 0;
      after_eop  = 0;
      bidx       = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(valid), 64'(1));
        chk("hold_beat", 64'({data, sop, eop, empty}), 64'(prev_beat));
      end
      if (in_pkt) chk("no_bubble", 64'(valid), 64'(1));
      if (after_eop) begin
        if (!valid) gap_run++;
        else begin
          chk("gap_idle", 64'(gap_run >= GAPC), 64'(1));
          after_eop = 0;
        end
      end
      if (valid && ready) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(data), 64'(e.data));
          chk("beat_sop", 64'(sop), 64'(e.sop));
          chk("beat_eop", 64'(eop), 64'(e.eop));
          chk("beat_empty", 64'(empty), 64'(e.empty));
        end
        if (sop) begin
          chk("sop_pairing", 64'(in_pkt), 64'(0));
          in_pkt   = 1;
          bidx     = 0;
          sop_cnt++;
          sop_cyc  = cyc;
          last_hdr = data;
          hdrs.push_back(data);
        end else begin
          chk("beat_in_pkt", 64'(in_pkt), 64'(1));
          bidx++;
          if (bidx == 1) last_beat1 = data;
        end
        if (eop) begin
          in_pkt    = 0;
          eop_cnt++;
          eop_cyc   = cyc;
          after_eop = 1;
          gap_run   = 0;
        end
      end
      prev_stall = valid && !ready;
      prev_beat  = {data, sop, eop, empty};
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    int base, base_s, hbase;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_data", 64'(data), 64'(0));
    chk("rst_sop", 64'(sop), 64'(0));
    chk("rst_eop", 64'(eop), 64'(0));
    chk("rst_empty", 64'(empty), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_pkt_count", 64'(pkt_count), 64'(0));
    @(posedge clk); #1 rst = 1'b0;

    // single packet, ready held high
    ready_mode = 0;
    push_packet();
    pulse_start(2);
    wait_mon("t1_eop_timeout", 0, 1, 100);
    for (int i = 1; i <= int'(GAPC) + 1; i++) begin
      @(negedge clk);
      chk("t1_busy_gap", 64'(busy), 64'(i <= int'(GAPC)));
      if (i == 1) begin
        chk("t1_valid_after_eop", 64'(valid), 64'(0));
        chk("t1_pkt_count", 64'(pkt_count), 64'(model_cnt));
      end
    end
    chk("t1_burst_len", 64'(eop_cyc - sop_cyc), 64'(PKT - 1));
    chk("t1_hdr", 64'(last_hdr), 64'(32'hA55A_0000));
    chk("t1_beat1", 64'(last_beat1), 64'(BEAT1_EXP));

    // toggling and random backpressure
    ready_mode = 1;
    push_packet();
    pulse_start(8);
    wait_mon("t2_eop_timeout", 0, 2, 200);
    ready_mode = 2;
    push_packet();
    pulse_start(8);
    wait_mon("t2r_eop_timeout", 0, 3, 400);
    repeat (10) @(negedge clk);
    chk("t2_pkt_count", 64'(pkt_count), 64'(model_cnt));

    // start pulses while busy are dropped
    push_packet();
    pulse_start(8);
    pulse_start(0);
    wait_mon("t3_eop_timeout", 0, 4, 400);
    pulse_start(0);
    repeat (30) @(negedge clk);
    chk("t3_pkt_count", 64'(pkt_count), 64'(model_cnt));
    chk("t3_busy", 64'(busy), 64'(0));
    chk("t3_sb_empty", 64'(exp_q.size()), 64'(0));

    // reset mid-packet
    ready_mode = 0;
    push_packet();
    pulse_start(8);
    wait_mon("t5_beat_timeout", 2, 7, 100);
    ready_mode = 3;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_valid", 64'(valid), 64'(0));
    chk("t5_pkt_count", 64'(pkt_count), 64'(0));
    chk("t5_busy", 64'(busy), 64'(0));
    chk("t5_sop_eop", 64'({sop, eop}), 64'(0));
    chk("t5_data", 64'(data), 64'(0));
    exp_q.delete();
    model_seq = 0;
    model_cnt = 0;
    ready_mode = 0;
    @(posedge clk); #1 rst = 1'b0;
    base = eop_cnt;
    push_packet();
    pulse_start(4);
    wait_mon("t5b_eop_timeout", 0, base + 1, 100);
    chk("t5_hdr_seq0", 64'(last_hdr), 64'(32'hA55A_0000));
    chk("t5_beat1", 64'(last_beat1), 64'(BEAT1_EXP));

    // continuous mode, three packets
    repeat (8) @(posedge clk);
    do_reset();
    base   = eop_cnt;
    base_s = sop_cnt;
    hbase  = hdrs.size();
    for (int p = 0; p < 3; p++) push_packet();
    @(posedge clk); #1 continuous = 1'b1;
    wait_mon("t4_sop_timeout", 1, base_s + 3, 300);
    @(posedge clk); #1 continuous = 1'b0;
    wait_mon("t4_eop_timeout", 0, base + 3, 100);
    repeat (20) @(negedge clk);
    chk("t4_no_restart", 64'(sop_cnt), 64'(base_s + 3));
    chk("t4_pkt_count", 64'(pkt_count), 64'(3));
    for (int i = 0; i < 3; i++)
      chk("t4_hdr", 64'(hdrs[hbase + i]), 64'(32'hA55A_0000 + i));

    repeat (5) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
